// File: rtl/rv32m_mul_seq.sv
`timescale 1ns/1ps
// Sequential wrapper around a 32x32->64 unsigned multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Operands are captured as magnitudes and held so the multiplier can be timed as a multicycle path.
module rv32m_mul_seq #(
  parameter int unsigned LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [4:0]  rd_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready is high only in IDLE; out_valid stays high with result/rd_out frozen until out_ready.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [3:0] CNT_INIT  = 4'(LAT - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        sampled;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        neg_q;
  logic [1:0]  op_q;
  logic [4:0]  rd_q;
  logic [63:0] prod_q;

  logic        a_neg_in;
  logic        b_neg_in;
  logic [31:0] a_mag_in;
  logic [31:0] b_mag_in;
  logic [63:0] u;
  logic [63:0] p;
  logic [31:0] word;

  // MUL takes the low word, which does not depend on operand signs, so no negation there.
  always_comb begin
    a_neg_in = rs1[31] & ((op == OP_MULH) | (op == OP_MULHSU));
    b_neg_in = rs2[31] & (op == OP_MULH);
    a_mag_in = a_neg_in ? (~rs1 + 32'd1) : rs1;
    b_mag_in = b_neg_in ? (~rs2 + 32'd1) : rs2;
  end

  // Multicycle path: a_mag/b_mag are held for LAT cycles before prod_q samples u.
  assign u = 64'(a_mag) * 64'(b_mag);

  // Sign correction and word select run from prod_q in a single-cycle stage.
  always_comb begin
    p    = neg_q ? (~prod_q + 64'd1) : prod_q;
    word = (op_q == OP_MUL) ? p[31:0] : p[63:32];
  end

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      sampled   <= 1'b0;
      a_mag     <= 32'd0;
      b_mag     <= 32'd0;
      neg_q     <= 1'b0;
      op_q      <= 2'b00;
      rd_q      <= 5'd0;
      prod_q    <= 64'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= 32'd0;
      rd_out    <= 5'd0;
    end else if (flush) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      sampled   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            a_mag    <= a_mag_in;
            b_mag    <= b_mag_in;
            neg_q    <= a_neg_in ^ b_neg_in;
            op_q     <= op;
            rd_q     <= rd_in;
            cnt      <= CNT_INIT;
            sampled  <= 1'b0;
            state    <= S_CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_CALC: begin
          if (!sampled) begin
            if (cnt == 4'd0) begin
              prod_q  <= u;
              sampled <= 1'b1;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end else begin
            result    <= word;
            rd_out    <= rd_q;
            out_valid <= 1'b1;
            sampled   <= 1'b0;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          // in_ready returns one cycle after consumption, never in the consuming cycle.
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
